// File: rtl/common.sv
// Shared pipeline types for the five-stage RISC-V core.
// The IF/ID payload also serves as the fetch FIFO entry.
package common;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } if_id_type;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instruction} pairs between memory and IF/ID.
// BUF_DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
    import common::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  if_id_type                  push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(BUF_DEPTH):0] count_o,
    output if_id_type                  head_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    if_id_type        mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, fetch FIFO, IF/ID register.
// Optional fetch-bubble counter on port stall_count when FETCH_STALL_CNT_EN is defined.
module fetch_stage
    import common::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output if_id_type   if_id,
    output logic        if_id_valid
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        outstanding_q, outstanding_d;
    logic        drop_q, drop_d;
    if_id_type   if_id_q, if_id_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [CNT_W-1:0] fifo_count;
    if_id_type        fifo_head;
    if_id_type        rsp_entry;
    logic             gnt_fire, rsp, rsp_live, fifo_empty;
    logic             bypass, push, pop;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = |redirect_pc[1:0];

    // A free FIFO slot is reserved at issue so the returning word can never overflow it.
    assign imem_req   = reset_n && !outstanding_q && (fifo_count < CNT_W'(BUF_DEPTH)) && !redirect;
    assign imem_addr  = pc_q;
    assign gnt_fire   = imem_req && imem_gnt;
    assign rsp        = imem_rvalid && outstanding_q;
    assign rsp_live   = rsp && !drop_q && !redirect;
    assign fifo_empty = (fifo_count == '0);
    assign bypass     = rsp_live && !stall && fifo_empty;
    assign push       = rsp_live && !bypass;
    assign pop        = !redirect && !stall && !fifo_empty;
    assign rsp_entry  = '{pc: out_pc_q, instruction: imem_rdata};

    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .push_i      (push),
        .push_data_i (rsp_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        pc_d          = pc_q;
        out_pc_d      = out_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if_id_d       = if_id_q;
        if_id_valid_d = if_id_valid_q;

        if (gnt_fire) begin
            out_pc_d      = pc_q;
            pc_d          = pc_q + 32'd4;
            outstanding_d = 1'b1;
        end
        if (rsp) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end

        if (redirect) begin
            pc_d                = {redirect_pc[31:2], 2'b00};
            if_id_valid_d       = 1'b0;
            if_id_d.instruction = NOP_INSTR;
            if (outstanding_q && !rsp) drop_d = 1'b1;
        end else if (!stall) begin
            if (pop) begin
                if_id_d       = fifo_head;
                if_id_valid_d = 1'b1;
            end else if (bypass) begin
                if_id_d       = rsp_entry;
                if_id_valid_d = 1'b1;
            end else begin
                if_id_valid_d       = 1'b0;
                if_id_d.instruction = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            out_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            if_id_q       <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            out_pc_q      <= out_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if_id_q       <= if_id_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id       = if_id_q;
    assign if_id_valid = if_id_valid_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // A bubble is a cycle decode could have accepted but IF/ID ends up empty.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!stall && !if_id_valid_d && (stall_count_q != '1))
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_count_q <= '0;
        else          stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage RISC-V pipeline. It owns the program counter and issues word requests to instruction memory over a request/grant/response handshake. Returned words are buffered in a small FIFO, and each one is delivered with its PC to the decode stage through the IF/ID pipeline register. The stage honours decode back-pressure (`stall`) and branch redirects from execute, discarding any wrong-path work.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `BUF_DEPTH`, default 2: fetch FIFO entries; must be a power of two, at least 2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request word address; always equals `pc`.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in 32: response instruction word.
- `stall` in 1: decode cannot accept; hold IF/ID.
- `redirect` in 1: taken branch/jump resolved.
- `redirect_pc` in 32: new fetch target; bits [1:0] are ignored and forced to 0.
- `if_id` out `if_id_type`: PC and instruction to decode.
- `if_id_valid` out 1: `if_id` holds a live instruction.
- `stall_count` out 32: present only with `FETCH_STALL_CNT_EN`.

## Operation
- State: `pc`, `outstanding` (1 bit), `out_pc`, `drop` (1 bit), FIFO, IF/ID register.
- Reset values: `pc`=`RESET_PC`, `outstanding`=0, `drop`=0, FIFO empty, `if_id`=0, `if_id_valid`=0, `imem_req`=0 during reset, `stall_count`=0.
- Request issue: `imem_req` = !`outstanding` && (fifo_count < `BUF_DEPTH`) && !`redirect`. At most one request is outstanding.
- Grant (`imem_req && imem_gnt`):
  - `out_pc`<=`pc`, `pc`<=`pc`+4, `outstanding`<=1.
  - PC wraps modulo 2^32, from 32'hFFFF_FFFC to 0.
- Response (`imem_rvalid`):
  - `outstanding`<=0.
  - If `drop`, discard the word and clear `drop`.
  - Otherwise write {`out_pc`, `imem_rdata`} into the FIFO, or bypass it (see next item).
- IF/ID load:
  - When !`stall`, `if_id` loads the FIFO head and pops it. If the FIFO is empty and a non-dropped response arrives, the response bypasses the FIFO into `if_id`.
  - With no source available, `if_id_valid`<=0.
  - When `stall`, `if_id` and `if_id_valid` hold.
  - Push and pop in the same cycle are legal at any occupancy.
- Redirect has the highest priority and overrides `stall`:
  - `pc`<=`redirect_pc`, the FIFO is flushed, and `if_id_valid`<=0.
  - If a request is outstanding and its response is not arriving this cycle, `drop`<=1.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
- A stale response is never delivered, whatever the redirect timing.
- `imem_rvalid` with no outstanding request is a protocol error and is ignored.
- Responses never overflow the FIFO, because issue reserves a slot.

## Timing
- Reset release: first `imem_req`=1 (addr `RESET_PC`) in the first cycle after `reset_n` rises.
- Zero-wait memory (gnt in cycle N, rvalid in N+1): `if_id_valid`=1 in N+2. Sustained throughput is one instruction per 2 cycles (single outstanding request).
- Redirect in cycle R: request for `redirect_pc` in R+1 at earliest; first new instruction visible in R+3 with zero-wait memory.
- Asynchronous reset mid-operation clears all state immediately, including `drop`. Responses pending across reset are the memory's responsibility.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_count` port exists.
  - It increments by 1 every cycle with !`stall` && !`if_id_valid` after the edge (fetch bubble).
  - It saturates at 32'hFFFF_FFFF and resets to 0.
- Not defined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `common`: reuse `if_id_type` as the FIFO entry type. Add `localparam logic [31:0] NOP_INSTR = 32'h0000_0013`. `if_id.instruction` is set to `NOP_INSTR` whenever `if_id_valid` is cleared.
- One sub-module, `fetch_fifo`: parameterised by `BUF_DEPTH`.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory returning addr as data → `if_id` shows pc 0x100, 0x104, 0x108 in order, `if_id_valid` pulses.
- Hold `stall`=1 for 6 cycles mid-stream → `if_id` frozen, FIFO fills to 2, `imem_req` drops, then resumes in order with no loss.
- `redirect`=1 to 0x2001 while a request is outstanding with 3-cycle latency → stale word dropped, next delivered pc 0x2000.
- `redirect` coincident with `imem_rvalid` and `stall`=1 → response discarded, `if_id_valid`=0, fetch resumes at the new target.
- `redirect_pc`=32'hFFFF_FFFC → pc sequence 0xFFFF_FFFC, 0x0000_0000.
- With `FETCH_STALL_CNT_EN`: 4-cycle grant delay, `stall`=0 → `stall_count` increments by one per bubble cycle; without the macro, the bench compiles with no `stall_count` port.
